// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU-wide constants and types for the GPR file and its write-port
// scheduler.
//   REG_W      : GPR address width
//   DATA_W     : GPR data width
//   NUM_REGS   : number of architectural GPRs (r0 is hard-wired zero)
//   wbEntry_t  : one buffered long-unit result {waddr, wdata}
//   wbSrc_t    : which requester owns the regfile write port this cycle
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;

   typedef logic [REG_W-1:0]  regAddr_t;
   typedef logic [DATA_W-1:0] regData_t;

   typedef struct packed {
      regAddr_t waddr;
      regData_t wdata;
   } wbEntry_t;

   localparam int WB_ENTRY_W = $bits(wbEntry_t);

   // SRC_NONE covers both "nobody writes" and "write to r0 swallowed".
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_FIFO = 2'd2
   } wbSrc_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO holding long-unit results until they win the
// regfile write port. The head is presented combinationally so the
// scheduler can route it to the regfile in the grant cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write pushData this cycle (ignored when full)
//   pushData   : entry to append
//   pop        : drop the head this cycle (ignored when empty)
//   headData   : current head entry (valid when !empty)
//   full,empty : status, derived purely from registered pointers
// ---------------------------------------------------------------------------
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] headData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when the
   // index bits coincide.
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush;
   logic             doPop;

   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   assign headData = mem[rdPtr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + (AW+1)'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + (AW+1)'(1);
         end
      end
   end

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (doPush && !rst) begin
         mem[wrPtr[AW-1:0]] <= pushData;
      end
   end

endmodule

// File: rtl/regfile_wb_sched.sv
// ---------------------------------------------------------------------------
// regfile_wb_sched
// Shares the single (negedge) GPR write port between the in-order pipeline
// writeback and buffered long-unit results, and keeps a scoreboard of
// registers still waiting on a long-unit result so issue can stall on
// RAW/WAW hazards.
// Parameters:
//   DEPTH      : long-unit result FIFO entries (power of two, >= 2)
//   STARVE_MAX : consecutive lost arbitrations before the FIFO head is forced
// Ports:
//   clk, rst                       : clock, async active-high reset
//   pipe_we/pipe_waddr/pipe_wdata  : pipeline writeback request
//   pipe_stall                     : writeback not taken; pipe holds request
//   lu_valid/lu_waddr/lu_wdata     : long-unit result
//   lu_ready                       : FIFO not full
//   iss_valid/iss_waddr            : long op issued; mark destination pending
//   chk_rs/chk_rt/chk_rd           : registers of the instruction in issue
//   chk_busy                       : any non-zero chk_* register is pending
//   rf_we/rf_waddr/rf_wdata        : regfile write port
// ---------------------------------------------------------------------------
module regfile_wb_sched
   import cpu_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_we,
   input  logic [REG_W-1:0]  pipe_waddr,
   input  logic [DATA_W-1:0] pipe_wdata,
   output logic              pipe_stall,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [REG_W-1:0]  lu_waddr,
   input  logic [DATA_W-1:0] lu_wdata,
   input  logic              iss_valid,
   input  logic [REG_W-1:0]  iss_waddr,
   input  logic [REG_W-1:0]  chk_rs,
   input  logic [REG_W-1:0]  chk_rt,
   input  logic [REG_W-1:0]  chk_rd,
   output logic              chk_busy,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int              SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

   // ------------------------------------------------------------------
   // Long-unit result buffer
   // ------------------------------------------------------------------
   wbEntry_t pushEntry;
   wbEntry_t headEntry;
   logic     fifoFull;
   logic     fifoEmpty;
   logic     fifoPop;

   assign pushEntry.waddr = lu_waddr;
   assign pushEntry.wdata = lu_wdata;

   // Ready is a pure function of the registered full flag; a pop in the
   // same cycle does not make room until the next one.
   assign lu_ready = !fifoFull;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WB_ENTRY_W)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (lu_valid),
      .pushData (pushEntry),
      .pop      (fifoPop),
      .headData (headEntry),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // ------------------------------------------------------------------
   // Write-port arbitration and starve counter
   // ------------------------------------------------------------------
   logic [SW-1:0] starveCnt;
   logic [SW-1:0] starveNext;
   wbSrc_t        grantSrc;
   logic          pipeWants;
   logic          headIsR0;
   logic          fifoForced;

   always_comb begin
      grantSrc   = SRC_NONE;
      fifoPop    = 1'b0;
      pipe_stall = 1'b0;
      starveNext = starveCnt;

      // A pipe write to r0 is a no-op that never competes for the port.
      pipeWants  = pipe_we && (pipe_waddr != '0);
      headIsR0   = !fifoEmpty && (headEntry.waddr == '0);
      fifoForced = fifoFull || (starveCnt == STARVE_LIM);

      if (fifoEmpty) begin
         if (pipeWants) begin
            grantSrc = SRC_PIPE;
         end
      end else if (headIsR0) begin
         // r0 results are discarded without consuming the port.
         fifoPop = 1'b1;
         if (pipeWants) begin
            grantSrc = SRC_PIPE;
         end
      end else if (!pipeWants) begin
         grantSrc = SRC_FIFO;
         fifoPop  = 1'b1;
      end else if (fifoForced) begin
         grantSrc   = SRC_FIFO;
         fifoPop    = 1'b1;
         pipe_stall = 1'b1;
      end else begin
         // Pipe wins over a waiting head. The counter cannot pass the
         // limit: at the limit the branch above forces the FIFO instead.
         grantSrc   = SRC_PIPE;
         starveNext = starveCnt + SW'(1);
      end

      if (fifoPop) begin
         starveNext = '0;
      end

      // Nothing reaches the regfile while reset is held.
      if (rst) begin
         grantSrc   = SRC_NONE;
         fifoPop    = 1'b0;
         pipe_stall = 1'b0;
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      case (grantSrc)
         SRC_PIPE: begin
            rf_we    = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
         end
         SRC_FIFO: begin
            rf_we    = 1'b1;
            rf_waddr = headEntry.waddr;
            rf_wdata = headEntry.wdata;
         end
         default: begin
            rf_we    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starveCnt <= '0;
      end else begin
         starveCnt <= starveNext;
      end
   end

   // ------------------------------------------------------------------
   // Pending-register scoreboard (r0 has no entry)
   // ------------------------------------------------------------------
   logic [NUM_REGS-1:1] pending;
   logic [NUM_REGS-1:1] pendingNext;
   logic [NUM_REGS-1:1] pendSet;
   logic [NUM_REGS-1:1] pendClr;
   logic [NUM_REGS-1:0] pendFull;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : gPend
         assign pendSet[gi] = iss_valid && (iss_waddr == REG_W'(gi));
         assign pendClr[gi] = fifoPop && (headEntry.waddr == REG_W'(gi));
         // Set dominates clear so a fresh issue is never lost.
         assign pendingNext[gi] = pendSet[gi] | (pending[gi] & ~pendClr[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pendingNext;
      end
   end

   // Bit 0 reads as never pending, so r0 operands never stall issue.
   assign pendFull = {pending, 1'b0};
   assign chk_busy = pendFull[chk_rs] | pendFull[chk_rt] | pendFull[chk_rd];

   // Issuing to a register whose result is retiring in the same cycle
   // means issue ignored chk_busy on rd.
   logic setClrClash;
   assign setClrClash = iss_valid && (iss_waddr != '0) && fifoPop &&
                        (headEntry.waddr == iss_waddr);

   aSetClrClash: assert property (@(posedge clk) disable iff (rst) !setClrClash);

endmodule
